// File: rtl/counter_event_fifo.sv
// counter_event_fifo
//
// Event monitor that sits downstream of the up/down counter. It detects
// overflow, underflow and compare-match (rising edge) events, and queues
// each one with the count value at which it occurred in a small
// first-word-fall-through FIFO. The FIFO is drained through a valid/ready
// handshake.
//
// Optional feature macro: EVT_TIMESTAMP_EN
//   When defined, a free-running TS_WIDTH counter is captured per entry and
//   presented on o_evt_ts. When undefined, the timestamp logic and the
//   o_evt_ts port are absent.
//
// Parameters
//   WIDTH    : count value width
//   DEPTH    : FIFO entries (power of two, >= 2)
//   TS_WIDTH : timestamp width (only meaningful with EVT_TIMESTAMP_EN)
//
// Ports
//   i_clk        : clock
//   i_rst_n      : synchronous active-low reset
//   i_count      : counter value
//   i_ovf        : overflow flag, one event per high cycle
//   i_udf        : underflow flag, one event per high cycle
//   i_cmp_en     : compare-match detection enable
//   i_cmp_value  : compare value
//   i_evt_ready  : consumer ready
//   i_clr_drop   : clears the sticky drop flag
//   o_evt_valid  : FIFO not empty, head entry presented
//   o_evt_code   : head code (01 ovf, 10 udf, 11 compare match)
//   o_evt_count  : head captured count
//   o_evt_ts     : head captured timestamp (EVT_TIMESTAMP_EN only)
//   o_level      : occupied entries
//   o_drop       : sticky, an event was lost
module counter_event_fifo #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 4,
  parameter int TS_WIDTH = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [WIDTH-1:0]           i_count,
  input  logic                       i_ovf,
  input  logic                       i_udf,
  input  logic                       i_cmp_en,
  input  logic [WIDTH-1:0]           i_cmp_value,
  input  logic                       i_evt_ready,
  input  logic                       i_clr_drop,
  output logic                       o_evt_valid,
  output logic [1:0]                 o_evt_code,
  output logic [WIDTH-1:0]           o_evt_count,
`ifdef EVT_TIMESTAMP_EN
  output logic [TS_WIDTH-1:0]        o_evt_ts,
`endif
  output logic [$clog2(DEPTH+1)-1:0] o_level,
  output logic                       o_drop
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH+1);

  localparam logic [1:0] CODE_OVF = 2'b01;
  localparam logic [1:0] CODE_UDF = 2'b10;
  localparam logic [1:0] CODE_CMP = 2'b11;

  // Elaboration-time sanity check on the configuration.
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (TS_WIDTH < 1)) begin : g_param_check
    $error("counter_event_fifo: DEPTH must be a power of two >= 2 and TS_WIDTH >= 1");
  end

  logic             match_now;
  logic             match_q;
  logic             cmp_evt;
  logic             any_evt;
  logic             lost_prio;
  logic             lost_full;
  logic [1:0]       evt_code;
  logic             full;
  logic             push;
  logic             pop;

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [LVL_W-1:0] level;
  logic             drop;

  logic [1:0]       code_mem  [DEPTH];
  logic [WIDTH-1:0] count_mem [DEPTH];

  // Event detection and arbitration
  assign match_now = i_cmp_en && (i_count == i_cmp_value);
  assign cmp_evt   = match_now && !match_q;
  assign any_evt   = i_ovf || i_udf || cmp_evt;

  // Every lower-priority event beaten by a higher one in the same cycle is lost.
  assign lost_prio = (i_ovf && i_udf) || ((i_ovf || i_udf) && cmp_evt);

  always_comb begin
    evt_code = CODE_CMP;
    if (i_ovf) begin
      evt_code = CODE_OVF;
    end else if (i_udf) begin
      evt_code = CODE_UDF;
    end
  end

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign full      = (level == LVL_W'(DEPTH));
  assign pop       = o_evt_valid && i_evt_ready;
  assign push      = any_evt && (!full || pop);
  assign lost_full = any_evt && full && !pop;

  // Control state
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      match_q <= 1'b0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      level   <= '0;
      drop    <= 1'b0;
    end else begin
      match_q <= match_now;
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        level <= level + LVL_W'(1);
      end else if (pop && !push) begin
        level <= level - LVL_W'(1);
      end
      // Set has priority over clear so a loss is never hidden.
      if (lost_prio || lost_full) begin
        drop <= 1'b1;
      end else if (i_clr_drop) begin
        drop <= 1'b0;
      end
    end
  end

  // Entry storage (no reset; contents only observed while occupied)
  always_ff @(posedge i_clk) begin
    if (push) begin
      code_mem[wr_ptr]  <= evt_code;
      count_mem[wr_ptr] <= i_count;
    end
  end

  // Head presentation: zero when empty so outputs read 0 out of reset.
  assign o_evt_valid = (level != '0);
  assign o_evt_code  = o_evt_valid ? code_mem[rd_ptr]  : '0;
  assign o_evt_count = o_evt_valid ? count_mem[rd_ptr] : '0;
  assign o_level     = level;
  assign o_drop      = drop;

`ifdef EVT_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] ts_cnt;
  logic [TS_WIDTH-1:0] ts_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      ts_cnt <= '0;
    end else begin
      ts_cnt <= ts_cnt + TS_WIDTH'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      ts_mem[wr_ptr] <= ts_cnt;
    end
  end

  assign o_evt_ts = o_evt_valid ? ts_mem[rd_ptr] : '0;
`endif

endmodule

// File: doc/counter_event_fifo.md
# counter_event_fifo

Downstream event monitor for the up/down counter. Consumes the count value and the overflow/underflow flags, detects overflow, underflow and compare-match events, and queues each event with the count value at which it occurred in a small first-word-fall-through FIFO. Software or a downstream interrupt block drains the FIFO through a valid/ready handshake.

## Interface
- WIDTH, 32, bit width of the count value; matches the counter's WIDTH
- DEPTH, 4, FIFO entries; power of two, at least 2
- TS_WIDTH, 16, timestamp width; used only when EVT_TIMESTAMP_EN is defined

- i_clk  input  1  clock
- i_rst_n  input  1  reset: one clock, synchronous, active-low
- i_count  input  WIDTH  counter value, connected to the counter's o_count
- i_ovf  input  1  overflow flag, connected to the counter's o_ovf
- i_udf  input  1  underflow flag, connected to the counter's o_udf
- i_cmp_en  input  1  compare-match detection enable
- i_cmp_value  input  WIDTH  compare value
- i_evt_ready  input  1  consumer ready
- i_clr_drop  input  1  clears o_drop
- o_evt_valid  output  1  FIFO not empty; head entry presented
- o_evt_code  output  2  head event code: 01 = ovf, 10 = udf, 11 = cmp match
- o_evt_count  output  WIDTH  head entry's captured i_count
- o_evt_ts  output  TS_WIDTH  head entry's captured timestamp; present only with EVT_TIMESTAMP_EN
- o_level  output  $clog2(DEPTH+1)  number of occupied entries
- o_drop  output  1  sticky; set when an event was lost

## Operation
- **Match detection**
  - match_now = i_cmp_en && (i_count == i_cmp_value).
  - A registered flag match_q <= match_now on every cycle.
  - A compare event fires on the rising edge only: match_now && !match_q.
  - Dropping i_cmp_en clears match_q, so re-enabling while already matching fires one event.
- **One enqueue per cycle, by priority**
  - Priority order: ovf, then udf, then cmp.
  - Each lower-priority event that is suppressed in the same cycle sets o_drop.
  - Example: i_ovf together with a compare edge enqueues ovf and sets o_drop.
- **Push**
  - An event pushes when the FIFO is not full, or when it is full and a pop happens in the same cycle.
  - If the FIFO is full and there is no pop, the event is discarded and o_drop is set.
- **Entry contents**
  - code, i_count sampled in the event cycle, and the timestamp when configured.
- **Pop (first-word fall-through)**
  - Pop occurs when o_evt_valid && i_evt_ready.
  - The head fields are valid whenever o_evt_valid = 1.
  - The head fields must hold stable while o_evt_valid && !i_evt_ready.
- **o_level**
  - Increments on push only, decrements on pop only, unchanged on simultaneous push and pop.
  - Range 0..DEPTH.
- **o_drop**
  - Cleared by i_clr_drop.
  - A drop in the same cycle as i_clr_drop leaves o_drop = 1 (set wins).
- **Pointers**
  - Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - Full/empty is determined by the occupancy count.

## Timing
- **Reset (synchronous, i_rst_n = 0 at a rising i_clk)**
  - o_evt_valid = 0, o_level = 0, o_drop = 0.
  - o_evt_code = 0, o_evt_count = 0, o_evt_ts = 0.
  - match_q = 0, pointers = 0, timestamp counter = 0.
- **Reset mid-operation**
  - Flushes all entries.
  - Events present in the reset cycle are ignored.
- **Latency**
  - Event sampled at edge N gives o_evt_valid = 1 after edge N, when the FIFO was empty.
  - Event-to-output latency is 1 cycle.
- **Throughput**
  - Pop has no bubble: 1 entry per cycle with ready held high.
  - With ready held high, the FIFO sustains one push and one pop per cycle indefinitely.
- **Inputs**
  - i_ovf and i_udf are sampled as level-per-cycle; each high cycle is one event.

## Configuration
- Macro: EVT_TIMESTAMP_EN.
- **Defined**
  - A free-running TS_WIDTH counter increments every cycle and wraps from all-ones to 0.
  - The counter value in the event cycle is stored per entry and driven on o_evt_ts.
- **Undefined**
  - No timestamp counter and no storage.
  - The o_evt_ts port is absent; TS_WIDTH is ignored.
  - All other behaviour is identical.

## Test plan
- **Single ovf:** i_count = 32'hFFFF_FFFF, i_ovf = 1 for 1 cycle.
  - Next cycle: o_evt_valid = 1, o_evt_code = 01, o_evt_count = FFFF_FFFF, o_level = 1.
  - Pop with ready: o_level = 0.
- **Compare edge:** i_cmp_en = 1, i_cmp_value = 5, i_count held at 5 for 4 cycles.
  - Exactly one entry, code 11, count 5.
  - Toggling i_cmp_en 1→0→1 with i_count at 5 adds exactly one more entry.
- **Full/drop:** i_evt_ready = 0, 5 udf pulses with DEPTH = 4.
  - o_level = 4, o_drop = 1.
  - Drained entries are the first 4 in order.
  - i_clr_drop pulse gives o_drop = 0.
- **Simultaneous events:** i_ovf = 1 and a compare edge in the same cycle.
  - One entry, code 01; o_drop = 1.
- **Full with push and pop:** FIFO full, an event arrives with i_evt_ready = 1.
  - o_level stays 4, o_drop stays 0, the new entry lands at the tail.
- **Reset flush:** i_rst_n = 0 with 3 entries queued.
  - Next cycle: o_evt_valid = 0, o_level = 0.
  - With EVT_TIMESTAMP_EN, the timestamp restarts from 0.
